// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes and debounces an active-low key into level, strobes and a press count.
// Optional auto-repeat strobes are compiled in with BUTTON_DEBOUNCER_AUTO_REPEAT_EN.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNT_WIDTH = 8,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic [COUNT_WIDTH-1:0] press_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {RELEASED, HELD, REPEAT_WAIT, REPEAT_RUN} state_t;
  state_t state;
  logic [1:0] sync;
  logic key_s;
  logic [DW-1:0] db_cnt;
  logic armed;
  logic settle;
  assign key_s = ~sync[1];
  // armed adds the final stable sample so a new level needs DEBOUNCE_CYCLES+1 agreeing samples
  assign settle = key_s != pressed && db_cnt == DW'(DEBOUNCE_CYCLES - 1) && armed;
  always_ff @(posedge clock) begin
    if (reset) sync <= 2'b11;
    else sync <= {sync[0], key_n};
  end
  always_ff @(posedge clock) begin
    if (reset || key_s == pressed || settle) begin
      db_cnt <= '0;
      armed <= 1'b0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) armed <= 1'b1;
    else db_cnt <= db_cnt + 1'b1;
  end
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  logic [RW-1:0] rpt_cnt;
  logic rpt_due;
  assign rpt_due = state == REPEAT_RUN ? rpt_cnt == RW'(REPEAT_PERIOD - 1) : rpt_cnt == RW'(REPEAT_DELAY - 1);
`else
  assign repeat_pulse = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RELEASED;
      pressed <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      press_count <= '0;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
      repeat_pulse <= 1'b0;
      rpt_cnt <= '0;
`endif
    end else begin
      press_pulse <= settle && state == RELEASED;
      release_pulse <= settle && state != RELEASED;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
      repeat_pulse <= 1'b0;
`endif
      if (settle && state == RELEASED) begin
        state <= HELD;
        pressed <= 1'b1;
        press_count <= press_count + 1'b1;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
        rpt_cnt <= '0;
`endif
      end else if (settle) begin
        state <= RELEASED;
        pressed <= 1'b0;
      end
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
      // a release on the same edge takes priority over a due repeat
      else if (state != RELEASED) begin
        if (rpt_due) begin
          repeat_pulse <= 1'b1;
          rpt_cnt <= '0;
          state <= REPEAT_RUN;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
          if (state == HELD) state <= REPEAT_WAIT;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed scoreboard bench for button_debouncer (DEBOUNCE_CYCLES=4, COUNT_WIDTH=3).
module tb_button_debouncer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic key_n = 1'b1;
  logic pressed, press_pulse, release_pulse, repeat_pulse;
  logic [2:0] press_count;
  typedef struct {int cyc; int kind; logic [2:0] cnt;} evt_t;
  evt_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int p = 0;
  logic exp_pressed = 1'b0;
  logic [2:0] model_cnt = 3'd0;
  bit mon_en = 1'b0;

  button_debouncer #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(3), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
    .clock(clock), .reset(reset), .key_n(key_n), .pressed(pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse), .press_count(press_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_pressed"}, {7'd0, pressed}, 8'd0);
    chk({name, "_press_pulse"}, {7'd0, press_pulse}, 8'd0);
    chk({name, "_release_pulse"}, {7'd0, release_pulse}, 8'd0);
    chk({name, "_repeat_pulse"}, {7'd0, repeat_pulse}, 8'd0);
    chk({name, "_press_count"}, {5'd0, press_count}, 8'd0);
  endtask

  task automatic expect_evt(input int kind, input int at);
    evt_t e;
    if (kind == 0) model_cnt = model_cnt + 3'd1;
    e.cyc = at;
    e.kind = kind;
    e.cnt = model_cnt;
    q.push_back(e);
  endtask

  task automatic chk_evt(input int kind);
    evt_t e;
    checks++;
    assert (q.size() != 0) else begin
      failures++;
      $error("FAIL unexpected_strobe cyc=%0d got kind=%0d exp=none", cyc, kind);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      assert (e.cyc == cyc && e.kind == kind && e.cnt === press_count) else begin
        failures++;
        $error("FAIL strobe got kind=%0d cyc=%0d count=%0d exp kind=%0d cyc=%0d count=%0d",
               kind, cyc, press_count, e.kind, e.cyc, e.cnt);
      end
      if (e.kind == 0) exp_pressed = 1'b1;
      if (e.kind == 1) exp_pressed = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (press_pulse) chk_evt(0);
      if (release_pulse) chk_evt(1);
      if (repeat_pulse) chk_evt(2);
      chk("pressed", {7'd0, pressed}, {7'd0, exp_pressed});
      chk("press_release_overlap", {7'd0, press_pulse & release_pulse}, 8'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic key_press();
    key_n = 1'b0;
    expect_evt(0, cyc + 7);
  endtask

  task automatic key_release();
    key_n = 1'b1;
    expect_evt(1, cyc + 7);
  endtask

  task automatic pulse_reset(input string name);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_zero(name);
    exp_pressed = 1'b0;
    model_cnt = 3'd0;
  endtask

  initial begin
    idle(3);
    check_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    key_press();
    idle(20);
    key_release();
    idle(10);
    key_n = 1'b0;
    idle(3);
    key_n = 1'b1;
    idle(1);
    key_n = 1'b0;
    idle(2);
    key_n = 1'b1;
    idle(1);
    key_press();
    idle(15);
    key_release();
    idle(10);
    pulse_reset("rst_idle");
    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      key_press();
      idle(12);
      key_release();
      idle(12);
    end
    key_press();
    idle(12);
    key_release();
    idle(12);
    key_press();
    idle(12);
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL pending_before_reset got=%0d exp=0", q.size());
    end
    pulse_reset("rst_held");
    expect_evt(0, cyc + 7);
    p = cyc + 7;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    for (int k = 10; k < 34; k += 3) expect_evt(2, p + k);
`endif
    mon_en = 1'b1;
    idle(34);
    key_release();
    idle(12);
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL missing_strobes got=%0d exp=0", q.size());
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
